instruction_cache: RTL and testbench

// Direct-mapped, read-only instruction cache between the CPU fetch stage and the
// 128-bit-block instruction memory. Returns a 32-bit instruction for a 10-bit

---
 rtl/instruction_cache.sv | 163 ++++++++++++++++
 tb/tb_instruction_cache.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// -----------------------------------------------------------------------------
// instruction_cache
// Direct-mapped, read-only instruction cache that sits between the CPU fetch
// stage and a 128-bit-block instruction memory. It has 8 lines of 16 bytes.
// A hit returns the addressed 32-bit word in the same cycle. A miss stalls the
// CPU, fetches the whole block from memory, installs it in the line, and then
// serves the re-evaluated access as a hit.
//
// Ports
//   clock         in   1    system clock, rising edge
//   reset         in   1    asynchronous, active-low reset
//   cpu_read      in   1    fetch request
//   cpu_address   in   10   byte PC: tag=[9:7], index=[6:4], offset=[3:2]
//   cpu_readinst  out  32   instruction word, valid when read && !busywait
//   cpu_busywait  out  1    stall to the CPU
//   mem_read      out  1    block-read request to instruction memory
//   mem_address   out  6    block address {tag,index}
//   mem_readinst  in   128  memory block, byte k in bits [8k+7:8k]
//   mem_busywait  in   1    memory busy; falls when mem_readinst is valid
// -----------------------------------------------------------------------------
module instruction_cache #(
    parameter int NUM_LINES = 8,
    parameter int LINE_W    = 128,
    parameter int ADDR_W    = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic [ADDR_W-1:0] cpu_address,
    output logic [31:0]       cpu_readinst,
    output logic              cpu_busywait,
    output logic              mem_read,
    output logic [5:0]        mem_address,
    input  logic [LINE_W-1:0] mem_readinst,
    input  logic              mem_busywait
);

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_e;

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   data_q [NUM_LINES];
    logic [2:0]          tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [5:0]          miss_addr_q, miss_addr_d;
    logic                seen_busy_q, seen_busy_d;
    logic [LINE_W-1:0]   block_q;
    logic [31:0]         readinst_q;

    logic                capture_en;
    logic                update_en;

    logic [2:0]          pc_tag;
    logic [2:0]          pc_idx;
    logic [1:0]          pc_off;
    logic                hit;
    logic                idle_hit;
    logic [LINE_W-1:0]   line;
    logic [31:0]         word;
    logic                unused_byte_bits;

    assign pc_tag = cpu_address[9:7];
    assign pc_idx = cpu_address[6:4];
    assign pc_off = cpu_address[3:2];
    // Byte-within-word bits carry no information for 32-bit fetches.
    assign unused_byte_bits = ^cpu_address[1:0];

    assign hit      = cpu_read & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);
    assign idle_hit = (state_q == IDLE) & hit;

    assign line = data_q[pc_idx];

    always_comb begin
        word = line[31:0];
        case (pc_off)
            2'd0: word = line[31:0];
            2'd1: word = line[63:32];
            2'd2: word = line[95:64];
            2'd3: word = line[127:96];
            default: word = line[31:0];
        endcase
    end

    // A hit is forwarded combinationally. Otherwise the last served word is held.
    assign cpu_readinst = idle_hit ? word : readinst_q;

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        seen_busy_d  = seen_busy_q;
        capture_en   = 1'b0;
        update_en    = 1'b0;
        cpu_busywait = 1'b0;
        mem_read     = 1'b0;
        mem_address  = 6'd0;
        case (state_q)
            IDLE: begin
                if (cpu_read && !hit) begin
                    cpu_busywait = 1'b1;
                    miss_addr_d  = cpu_address[9:4];
                    seen_busy_d  = 1'b0;
                    state_d      = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read     = 1'b1;
                mem_address  = miss_addr_q;
                cpu_busywait = 1'b1;
                // Memory may raise busywait a cycle after the request.
                // Only a fall after a sampled rise marks valid data.
                if (mem_busywait) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    capture_en  = 1'b1;
                    seen_busy_d = 1'b0;
                    state_d     = UPDATE;
                end
            end
            UPDATE: begin
                cpu_busywait = 1'b1;
                update_en    = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The stall must drop as soon as reset is asserted, even before the
        // registers have settled.
        if (!reset) begin
            cpu_busywait = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            miss_addr_q <= 6'd0;
            seen_busy_q <= 1'b0;
            valid_q     <= '0;
            readinst_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            seen_busy_q <= seen_busy_d;
            if (update_en) begin
                valid_q[miss_addr_q[2:0]] <= 1'b1;
            end
            if (idle_hit) begin
                readinst_q <= word;
            end
        end
    end

    // The storage arrays are not reset. The valid bits alone gate their use.
    always_ff @(posedge clock) begin
        if (capture_en) begin
            block_q <= mem_readinst;
        end
        if (update_en) begin
            data_q[miss_addr_q[2:0]] <= block_q;
            tag_q[miss_addr_q[2:0]]  <= miss_addr_q[5:3];
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

    logic         clock;
    logic         reset;
    logic         cpu_read;
    logic [9:0]   cpu_address;
    logic [31:0]  cpu_readinst;
    logic         cpu_busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinst;
    logic         mem_busywait;

    int n_checks;
    int n_fail;

    instruction_cache dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_read     (cpu_read),
        .cpu_address  (cpu_address),
        .cpu_readinst (cpu_readinst),
        .cpu_busywait (cpu_busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readinst (mem_readinst),
        .mem_busywait (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word w of memory block a is {a, w, 16'hBEEF}.
    function automatic logic [127:0] blk(input logic [5:0] a);
        logic [127:0] b;
        for (int w = 0; w < 4; w++) begin
            b[w*32 +: 32] = {2'b00, a, 8'(w), 16'hBEEF};
        end
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Serves one block read. It is called right after the missing access has
    // been driven and the first-cycle stall has been checked.
    task automatic serve_miss(input string tag, input logic [5:0] addr, input logic [31:0] exp_word);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); #1;
            if (mem_read) break;
        end
        check({tag, " mem_read"}, 32'(mem_read), 32'd1);
        check({tag, " mem_address"}, 32'(mem_address), 32'(addr));
        check({tag, " stall in MEM_READ"}, 32'(cpu_busywait), 32'd1);
        mem_busywait = 1'b1;
        @(negedge clock); #1;
        @(negedge clock); #1;
        mem_busywait = 1'b0;
        mem_readinst = blk(addr);
        @(negedge clock); #1;
        check({tag, " mem_read dropped"}, 32'(mem_read), 32'd0);
        check({tag, " stall in UPDATE"}, 32'(cpu_busywait), 32'd1);
        mem_readinst = '0;
        @(negedge clock); #1;
        check({tag, " stall released"}, 32'(cpu_busywait), 32'd0);
        check({tag, " word after refill"}, cpu_readinst, exp_word);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b0;
        cpu_read     = 1'b0;
        cpu_address  = 10'd0;
        mem_readinst = '0;
        mem_busywait = 1'b0;

        // Reset state
        #1;
        check("reset mem_read", 32'(mem_read), 32'd0);
        check("reset mem_address", 32'(mem_address), 32'd0);
        check("reset busywait", 32'(cpu_busywait), 32'd0);
        check("reset readinst", cpu_readinst, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Cold miss at 0x000
        @(negedge clock);
        cpu_read    = 1'b1;
        cpu_address = 10'h000;
        #1;
        check("cold busywait same cycle", 32'(cpu_busywait), 32'd1);
        check("cold mem_read not yet", 32'(mem_read), 32'd0);
        serve_miss("cold", 6'h00, 32'h0000BEEF);

        // Sequential hits in block 0
        @(negedge clock); cpu_address = 10'h004; #1;
        check("hit4 busywait", 32'(cpu_busywait), 32'd0);
        check("hit4 mem_read", 32'(mem_read), 32'd0);
        check("hit4 word", cpu_readinst, 32'h0001BEEF);
        @(negedge clock); cpu_address = 10'h008; #1;
        check("hit8 busywait", 32'(cpu_busywait), 32'd0);
        check("hit8 mem_read", 32'(mem_read), 32'd0);
        check("hit8 word", cpu_readinst, 32'h0002BEEF);
        @(negedge clock); cpu_address = 10'h00C; #1;
        check("hitC busywait", 32'(cpu_busywait), 32'd0);
        check("hitC mem_read", 32'(mem_read), 32'd0);
        check("hitC word", cpu_readinst, 32'h0003BEEF);

        // Conflict on index 0
        @(negedge clock); cpu_address = 10'h080; #1;
        check("conflict miss", 32'(cpu_busywait), 32'd1);
        serve_miss("conflict", 6'h08, 32'h0800BEEF);
        @(negedge clock); cpu_address = 10'h000; #1;
        check("evicted miss", 32'(cpu_busywait), 32'd1);
        serve_miss("refetch", 6'h00, 32'h0000BEEF);

        // Distinct index 7 leaves line 0 intact
        @(negedge clock); cpu_address = 10'h3F0; #1;
        check("line7 miss", 32'(cpu_busywait), 32'd1);
        serve_miss("line7", 6'h3F, 32'h3F00BEEF);
        @(negedge clock); cpu_address = 10'h000; #1;
        check("line0 still hits", 32'(cpu_busywait), 32'd0);
        check("line0 word", cpu_readinst, 32'h0000BEEF);
        @(negedge clock); cpu_address = 10'h3FC; #1;
        check("line7 hit busywait", 32'(cpu_busywait), 32'd0);
        check("line7 word3", cpu_readinst, 32'h3F03BEEF);

        // Idle: no request, no memory traffic, output held
        @(negedge clock); cpu_read = 1'b0; cpu_address = 10'h080;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle busywait", 32'(cpu_busywait), 32'd0);
            check("idle mem_read", 32'(mem_read), 32'd0);
            check("idle readinst held", cpu_readinst, 32'h3F03BEEF);
            @(negedge clock);
            cpu_address = cpu_address + 10'h124;
        end

        // Reset during MEM_READ
        cpu_read    = 1'b1;
        cpu_address = 10'h080;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); #1;
            if (mem_read) break;
        end
        check("pre-reset mem_read", 32'(mem_read), 32'd1);
        mem_busywait = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid reset mem_read", 32'(mem_read), 32'd0);
        check("mid reset busywait", 32'(cpu_busywait), 32'd0);
        check("mid reset mem_address", 32'(mem_address), 32'd0);
        check("mid reset readinst", cpu_readinst, 32'd0);
        @(negedge clock);
        mem_busywait = 1'b0;
        reset        = 1'b1;
        #1;
        check("post reset fresh miss", 32'(cpu_busywait), 32'd1);
        serve_miss("post reset", 6'h08, 32'h0800BEEF);
        // Line 7 was filled before the reset and must now miss.
        @(negedge clock); cpu_address = 10'h3F0; #1;
        check("line7 invalidated", 32'(cpu_busywait), 32'd1);
        cpu_read = 1'b0;
        @(negedge clock); #1;
        check("dropped request no fetch", 32'(mem_read), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
